cmos_dvp_tx: RTL and testbench
==============================

# cmos_dvp_tx

DVP camera-bus transmitter: the source end of the OV7725-style interface that our capture path consumes. It emits cam_vsync, cam_href and byte-serial RGB565 on cam_data, synchronous to cam_pclk. Pixel data comes either from an upstream show-ahead source via a request strobe, or from an internal 8-bar colour generator. Used as a sensor emulator for bring-up, and as a loopback source for the capture/tailor chain.

## Interface
Parameters:
- H_ACT, 640: active pixels per line; multiple of 8.
- H_BLANK, 144: href-low pclk cycles per line; must be ≥ 2.
- V_SYNC, 4: lines with vsync high.
- V_BP, 18: blank lines between vsync fall and the first active line.
- V_ACT, 480: active lines.
- V_FP, 8: blank lines after the last active line.
- Derived: H_TOTAL = 2*H_ACT + H_BLANK cycles per line.

Ports:
- cam_pclk, in, 1: the single clock. All logic is on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- tx_en, in, 1: enable frame transmission.
- pattern_sel, in, 1: 1 selects the internal colour bars; 0 selects pixel_data.
- pixel_data, in, 16: RGB565 from the upstream source. It must be valid in any cycle where pix_req is high.
- pix_req, out, 1: per-pixel fetch strobe. pixel_data is captured at the end of a pix_req cycle.
- cam_vsync, out, 1: frame sync, active high.
- cam_href, out, 1: line-valid, active high.
- cam_data, out, 8: byte data, high byte first.
- frame_done, out, 1: one-cycle pulse at the end of each frame.

## Operation
- FSM states: IDLE, VSYNC, VBP, ACTIVE, VFP.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps every line.
  - line_cnt counts lines within the current state.
- All outputs are registered.
- State transitions:
  - IDLE→VSYNC: on a cycle where tx_en=1. h_cnt and line_cnt are cleared. pattern_sel is latched and held for the whole frame.
  - VSYNC→VBP after V_SYNC lines; VBP→ACTIVE after V_BP lines; ACTIVE→VFP after V_ACT lines.
  - End of VFP: go to VSYNC if tx_en=1 (pattern_sel is re-latched), otherwise to IDLE.
- tx_en is examined only in IDLE and at the end of VFP. Deasserting it mid-frame lets the current frame complete.
- cam_vsync is 1 exactly during VSYNC.
- In ACTIVE, for each line:
  - cam_href=1 for h_cnt < 2*H_ACT, then 0 for H_BLANK cycles.
  - cam_data carries pixel p's high byte at h_cnt=2p and its low byte at h_cnt=2p+1.
- cam_data is 0x00 whenever cam_href=0.
- External mode (latched pattern_sel=0):
  - pix_req pulses once per pixel, in the cycle before that pixel's high-byte cycle. This gives H_ACT pulses per active line and none elsewhere.
  - The captured word is held in a 16-bit register until its low byte has been sent.
- Pattern mode (latched pattern_sel=1):
  - pix_req stays 0.
  - Bar b = p / (H_ACT/8) takes, in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- frame_done is high for one cycle, on the last cycle of VFP.
- Reset (asynchronous assert at any time, including mid-line):
  - State goes to IDLE and all counters clear.
  - cam_vsync=0, cam_href=0, cam_data=0x00, pix_req=0, frame_done=0.
  - After release, the next frame starts from VSYNC.

## Timing
- Latency from tx_en to sync: tx_en sampled high in IDLE at edge n gives cam_vsync=1 from edge n+1.
- Frame length: (V_SYNC+V_BP+V_ACT+V_FP)*H_TOTAL cycles; back-to-back frames have no gap.
- Line k of ACTIVE:
  - href rises at cycle L, where L = line start.
  - First pix_req at L-1; for external mode, the last cycle of the preceding line or blank period carries it.
  - Subsequent pix_req at L+1, L+3, …, L+2*H_ACT-3.
  - href falls at L+2*H_ACT.
- The vsync fall and the first href rise are separated by exactly V_BP*H_TOTAL cycles.
- pixel_data is sampled only on pix_req cycles. It is don't-care otherwise, and no stall or backpressure exists.
- tx_en toggling on non-boundary cycles has no effect on any output.

## Test plan
All scenarios use H_ACT=8, H_BLANK=4, V_SYNC=1, V_BP=2, V_ACT=3, V_FP=1, giving H_TOTAL=20 and a 140-cycle frame.
- Reset check: hold rst_n=0 → all outputs 0. Release with tx_en=0 for 50 cycles → outputs stay 0 and the FSM stays in IDLE.
- Pattern mode: tx_en=1, pattern_sel=1 for one frame →
  - vsync high for 20 cycles;
  - href rises 40 cycles after vsync falls;
  - 3 lines of 16 href cycles each;
  - cam_data per line = FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00;
  - pix_req never asserts; frame_done pulses at cycle 140.
- External mode: a scoreboard source increments pixel_data per pix_req, starting at 0x1234 →
  - 8 pix_req per line, 24 per frame;
  - cam_data = 12,34,12,35,…;
  - each pix_req precedes its high byte by exactly 1 cycle.
- Continuous frames: tx_en held high → the next vsync rises on the cycle after frame_done. Drop tx_en mid-frame → the frame completes, then the FSM returns to IDLE.
- Mode latch: toggle pattern_sel mid-ACTIVE → the current frame's mode is unchanged and the new mode applies from the next frame.
- Reset mid-line: assert rst_n while href=1 → href, vsync and data go 0 immediately. Release with tx_en=1 → a full frame starting from VSYNC follows.

Source files
------------

// File: rtl/cmos_dvp_tx.sv
// cmos_dvp_tx: DVP camera-bus source emitting vsync/href and byte-serial RGB565 from an upstream pixel source or internal colour bars
module cmos_dvp_tx #(
    parameter int H_ACT   = 640,
    parameter int H_BLANK = 144,
    parameter int V_SYNC  = 4,
    parameter int V_BP    = 18,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 8
) (
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        tx_en,
    input  logic        pattern_sel,
    input  logic [15:0] pixel_data,
    output logic        pix_req,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done
);
    localparam int H_TOTAL = 2 * H_ACT + H_BLANK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int V_M1 = V_SYNC > V_BP ? V_SYNC : V_BP;
    localparam int V_M2 = V_ACT > V_FP ? V_ACT : V_FP;
    localparam int LW = $clog2((V_M1 > V_M2 ? V_M1 : V_M2) + 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT2     = HW'(2 * H_ACT);
    localparam logic [HW-1:0] H_REQ_LAST = HW'(2 * H_ACT - 3);
    localparam logic [HW-1:0] BAR_W      = HW'(H_ACT / 4);
    localparam logic [LW-1:0] VS_LAST  = LW'(V_SYNC - 1);
    localparam logic [LW-1:0] VBP_LAST = LW'(V_BP - 1);
    localparam logic [LW-1:0] VA_LAST  = LW'(V_ACT - 1);
    localparam logic [LW-1:0] VFP_LAST = LW'(V_FP - 1);
    localparam logic [2:0] IDLE = 3'd0, VSYNC = 3'd1, VBP = 3'd2, ACTIVE = 3'd3, VFP = 3'd4;
    localparam logic [7:0][15:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                         16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};

    logic [2:0]    state;
    logic [HW-1:0] h_cnt;
    logic [LW-1:0] line_cnt;
    logic          mode;
    logic [15:0]   pix_word;

    // The counters run one cycle ahead of the registered outputs, so every
    // output is a pure function of the current position in the frame.
    logic          h_end, line_last, frame_end, start, act_byte, next_line_act, req_n;
    logic [2:0]    state_adv, bar;
    logic [15:0]   bar_rgb;
    logic [7:0]    data_n;

    assign h_end = h_cnt == H_LAST;
    assign line_last = line_cnt == (state == VSYNC ? VS_LAST : state == VBP ? VBP_LAST :
                                    state == ACTIVE ? VA_LAST : VFP_LAST);
    assign frame_end = state == VFP && line_last && h_end;
    assign start = tx_en && (state == IDLE || frame_end);
    assign state_adv = state == VSYNC ? VBP : state == VBP ? ACTIVE :
                       state == ACTIVE ? VFP : tx_en ? VSYNC : IDLE;
    assign act_byte = state == ACTIVE && h_cnt < H_ACT2;
    assign next_line_act = (state == VBP && line_last) || (state == ACTIVE && !line_last);
    // First fetch of a line sits on the last cycle of the previous line, the
    // rest on the low-byte cycles of the preceding pixel.
    assign req_n = !mode && ((act_byte && h_cnt[0] && h_cnt <= H_REQ_LAST) ||
                             (h_end && next_line_act));
    assign bar = 3'(h_cnt / BAR_W);
    assign bar_rgb = BARS[bar];
    // High byte comes straight from the source on the cycle after the fetch;
    // the low byte comes from the held word.
    assign data_n = !act_byte ? 8'h00 :
                    h_cnt[0] ? (mode ? bar_rgb[7:0] : pix_word[7:0]) :
                               (mode ? bar_rgb[15:8] : pixel_data[15:8]);

    // Frame sequencer: horizontal position, line within state, and state.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            h_cnt    <= '0;
            line_cnt <= '0;
        end else if (state == IDLE) begin
            state <= tx_en ? VSYNC : IDLE;
        end else begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end) begin
                line_cnt <= line_last ? '0 : line_cnt + 1'b1;
                if (line_last)
                    state <= state_adv;
            end
        end
    end

    // Source mode is sampled only when a frame begins and held for its duration.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n)
            mode <= 1'b0;
        else if (start)
            mode <= pattern_sel;
    end

    // Registered bus outputs and the held pixel word.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= 8'h00;
            pix_req    <= 1'b0;
            frame_done <= 1'b0;
            pix_word   <= 16'h0000;
        end else begin
            cam_vsync  <= state == VSYNC;
            cam_href   <= act_byte;
            cam_data   <= data_n;
            pix_req    <= req_n;
            frame_done <= frame_end;
            if (pix_req)
                pix_word <= pixel_data;
        end
    end
endmodule

// File: tb/tb_cmos_dvp_tx.sv
// tb_cmos_dvp_tx: frame-level checks of cmos_dvp_tx against a position-based reference model
module tb_cmos_dvp_tx;
    localparam int HA = 8, HB = 4, VS = 1, VBP = 2, VA = 3, VF = 1;
    localparam int HT = 2 * HA + HB;
    localparam int FL = (VS + VBP + VA + VF) * HT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_en = 1'b0;
    logic        pattern_sel = 1'b0;
    logic [15:0] pixel_data = 16'h0000;
    logic        pix_req, cam_vsync, cam_href, frame_done;
    logic [7:0]  cam_data;

    int checks = 0;
    int failures = 0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef struct {
        logic        mode;
        logic [15:0] base;
        logic        nen;
        logic        nmode;
        int          exp_req;
        int          exp_href;
    } frame_t;

    frame_t tbl [4];

    always #5 clk = ~clk;

    cmos_dvp_tx #(
        .H_ACT(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BP(VBP), .V_ACT(VA), .V_FP(VF)
    ) dut (
        .cam_pclk(clk), .rst_n(rst_n), .tx_en(tx_en), .pattern_sel(pattern_sel),
        .pixel_data(pixel_data), .pix_req(pix_req), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_data(cam_data), .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] obs();
        return {cam_vsync, cam_href, pix_req, frame_done, cam_data};
    endfunction

    // Output cycle t (1..FL) of a frame: is it a high-byte cycle of an active line?
    function automatic logic is_hb(input int t);
        int line, col;
        if (t < 1 || t > FL) return 1'b0;
        line = (t - 1) / HT;
        col = (t - 1) % HT;
        return line >= VS + VBP && line < VS + VBP + VA && col < 2 * HA && col % 2 == 0;
    endfunction

    // Expected {vsync, href, req, done, data} at output cycle t of a frame.
    function automatic logic [11:0] model(input int t, input logic m, input logic [15:0] base);
        int line, col, ai, p;
        logic [15:0] px;
        logic vs, hr, rq, dn;
        logic [7:0] d;
        line = (t - 1) / HT;
        col = (t - 1) % HT;
        ai = line - (VS + VBP);
        p = col / 2;
        vs = line < VS;
        hr = line >= VS + VBP && line < VS + VBP + VA && col < 2 * HA;
        px = m ? bars[p / (HA / 8)] : base + 16'(ai * HA + p);
        d = !hr ? 8'h00 : (col % 2 == 0 ? px[15:8] : px[7:0]);
        rq = !m && is_hb(t + 1);
        dn = t == FL;
        return {vs, hr, rq, dn, d};
    endfunction

    task automatic run_frame(input logic m, input logic [15:0] base, input logic nen,
                             input logic nmode, output int reqs, output int hrefs);
        logic [15:0] src;
        src = base;
        reqs = 0;
        hrefs = 0;
        for (int t = 1; t <= FL; t++) begin
            @(negedge clk);
            check($sformatf("frame t%0d", t), 32'(obs()), 32'(model(t, m, base)));
            hrefs += int'(cam_href);
            if (pix_req) begin
                reqs++;
                pixel_data = src;
                src = src + 16'd1;
            end else begin
                pixel_data = 16'($urandom);
            end
            if (t >= FL - 1) begin
                tx_en = nen;
                pattern_sel = nmode;
            end else begin
                tx_en = 1'($urandom);
                pattern_sel = 1'($urandom);
            end
        end
    endtask

    initial begin
        int reqs, hrefs;
        tbl[0] = '{1'b1, 16'h0000, 1'b1, 1'b0, 0, VA * 2 * HA};
        tbl[1] = '{1'b0, 16'h1234, 1'b1, 1'b1, VA * HA, VA * 2 * HA};
        tbl[2] = '{1'b1, 16'h0000, 1'b1, 1'b0, 0, VA * 2 * HA};
        tbl[3] = '{1'b0, 16'($urandom), 1'b0, 1'b0, VA * HA, VA * 2 * HA};

        repeat (3) @(negedge clk);
        check("reset outputs", 32'(obs()), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            pattern_sel = 1'($urandom);
            pixel_data = 16'($urandom);
            check($sformatf("idle %0d", i), 32'(obs()), 32'h0);
        end

        tx_en = 1'b1;
        pattern_sel = tbl[0].mode;
        @(negedge clk);
        check("start latency", 32'(obs()), 32'h0);
        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i].mode, tbl[i].base, tbl[i].nen, tbl[i].nmode, reqs, hrefs);
            check($sformatf("frame %0d pix_req count", i), 32'(reqs), 32'(tbl[i].exp_req));
            check($sformatf("frame %0d href count", i), 32'(hrefs), 32'(tbl[i].exp_href));
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pattern_sel = 1'($urandom);
            check($sformatf("stopped %0d", i), 32'(obs()), 32'h0);
        end

        tx_en = 1'b1;
        pattern_sel = 1'b0;
        @(negedge clk);
        check("restart latency", 32'(obs()), 32'h0);
        tx_en = 1'b0;
        repeat (65) @(negedge clk);
        check("href before reset", 32'(cam_href), 32'h1);
        #2 rst_n = 1'b0;
        #1 check("async reset mid-line", 32'(obs()), 32'h0);
        @(negedge clk);
        check("held in reset", 32'(obs()), 32'h0);
        rst_n = 1'b1;
        tx_en = 1'b1;
        pattern_sel = 1'b1;
        @(negedge clk);
        check("post-reset start", 32'(obs()), 32'h0);
        run_frame(1'b1, 16'h0000, 1'b0, 1'b0, reqs, hrefs);
        check("post-reset pix_req count", 32'(reqs), 32'h0);
        check("post-reset href count", 32'(hrefs), 32'(VA * 2 * HA));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("final idle %0d", i), 32'(obs()), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
